ring_arbiter: RTL and testbench
===============================

# ring_arbiter

Round-robin arbiter that shares one resource among N requesters using a one-hot rotating priority token, the same scheme our ring counter provides. It issues a registered one-hot grant and holds it until the owner releases its request or a hold-time limit expires. The token then advances one position past the last owner. It sits between requester blocks and any shared datapath unit, such as a memory port or ALU, that accepts one user at a time.

## Interface

Parameters:
- N, 4, number of requesters (2..16)
- W, 2, width of owner index; N <= 2^W
- MAXHOLD, 8, maximum consecutive cycles one grant may be held (>= 1)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- en  input  1  allow new grants; does not revoke an existing grant
- req  input  N  per-requester request, level; held high while access is wanted
- grant  output  N  one-hot grant, registered; all-zero when idle
- owner  output  W  index of granted requester; 0 when idle
- busy  output  1  high when grant != 0
- expired  output  1  one-cycle pulse, first cycle after a grant was ended by MAXHOLD

## Operation

- State: IDLE or HELD. Also holds the one-hot priority pointer ptr (N bits), the hold counter cnt (count 0..MAXHOLD-1), and the current owner.
- Reset values: state IDLE, ptr = 1 (requester 0 highest), cnt = 0, grant = 0, owner = 0, busy = 0, expired = 0.
- Selection: the winner is the first set bit of req, searched starting at ptr's position and wrapping upward modulo N. The result is one-hot or zero.
- IDLE:
  - If en and req != 0: grant <= winner, owner <= its index, cnt <= 0, go HELD.
  - Otherwise stay in IDLE with grant = 0.
- HELD, each edge: a release occurs if req[owner] == 0; a timeout occurs if cnt == MAXHOLD-1 and req[owner] == 1.
  - On release or timeout: ptr <= owner rotated left by 1 with wrap, so bit N-1 goes to bit 0.
  - Rearbitration uses the new ptr. If en and any req is set, grant <= new winner and cnt <= 0, staying in HELD with no idle gap. Otherwise grant <= 0 and go IDLE.
  - On timeout only, expired <= 1 for exactly one cycle.
  - Otherwise: cnt <= cnt + 1, and grant and owner are unchanged.
- Sole requester on timeout: the same requester is regranted, with the expired pulse and cnt reset to 0. The owner is unchanged, but this still counts as a new grant.
- en low during HELD: the current grant runs to release or timeout, then the block goes IDLE.
- Requests from non-owners never affect the current grant.
- grant is always one-hot or zero. owner always matches grant.
- Reset mid-grant: all state returns to reset values on that edge, regardless of req or en.

## Timing

- Request to grant latency: req sampled high at edge t (IDLE, en = 1) gives grant high after edge t.
- A grant lasts at most MAXHOLD cycles. With req held, grant is high for exactly MAXHOLD cycles before the switch edge.
- Release: req[owner] low at edge t drops or transfers grant at edge t, so the owner sees grant for one cycle after lowering req at most.
- Back-to-back handoff: zero idle cycles when another requester is pending.
- expired is high for the cycle after the timeout edge only. It is never asserted on a release.
- busy equals |grant, registered with grant.

## Test plan

- Single request: after reset, req = 0001, en = 1, held 3 cycles then dropped. Required: grant = 0001 and owner = 0 one cycle after req; grant = 0000 and busy = 0 after the drop edge; ptr now favours requester 1.
- Full-load rotation: req = 1111 held with MAXHOLD = 8. Required: grant sequence 0001, 0010, 0100, 1000, 0001, each lasting exactly 8 cycles, with an expired pulse at every switch.
- Early release handoff: req = 0101, owner 0 drops req after 3 cycles. Required: grant goes 0001 to 0100 on the same edge with no gap; expired stays 0.
- Enable gating: en = 0, req = 0010 for 5 cycles. Required: grant = 0000. Then en = 1: grant = 0010 next cycle. Then en = 0 mid-grant: grant persists until release or timeout.
- Sole requester timeout: req = 1000 held for 20 cycles with MAXHOLD = 8. Required: grant stays 1000 throughout; expired pulses at cycles 9 and 17 after the first grant; owner = 3.
- Reset mid-grant: reset during grant = 0100. Required: grant = 0000 and owner = 0 the next edge. Then req = 1001: grant = 0001, showing ptr was restored to requester 0.

Source files
------------

// File: rtl/ring_arbiter_if.sv
// Request/grant bundle shared between requesters and ring_arbiter.
interface ring_arbiter_if #(
    parameter int N = 4,
    parameter int W = 2
);
    logic         en;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic [W-1:0] owner;
    logic         busy;
    logic         expired;

    modport master (
        output en,
        output req,
        input  grant,
        input  owner,
        input  busy,
        input  expired
    );

    modport slave (
        input  en,
        input  req,
        output grant,
        output owner,
        output busy,
        output expired
    );
endinterface

// File: rtl/ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority pointer and a
// per-grant hold limit. Grant, owner, busy and expired are all registered.
module ring_arbiter #(
    parameter int N       = 4,
    parameter int W       = 2,
    parameter int MAXHOLD = 8
) (
    input  logic          clk,
    input  logic          reset,
    ring_arbiter_if.slave bus
);
    localparam int CW = (MAXHOLD > 1) ? $clog2(MAXHOLD) : 1;

    typedef enum logic {IDLE, HELD} state_t;

    state_t         state, state_next;
    logic [N-1:0]   ptr, ptr_next;
    logic [N-1:0]   grant, grant_next;
    logic [W-1:0]   owner, owner_next;
    logic [CW-1:0]  cnt, cnt_next;
    logic           busy;
    logic           expired, expired_next;

    logic           release_hit;
    logic           timeout_hit;
    logic [N-1:0]   base_ptr;
    logic [W-1:0]   start_idx;
    logic [2*N-1:0] doubled;
    logic [N-1:0]   rot_req;
    logic [W-1:0]   first;
    logic [W:0]     sum;
    logic           found;
    logic [W-1:0]   win_idx;
    logic [N-1:0]   win_onehot;

    assign bus.grant   = grant;
    assign bus.owner   = owner;
    assign bus.busy    = busy;
    assign bus.expired = expired;

    // Detect end of the current grant and pick the pointer used for arbitration
    always_comb begin
        release_hit = (state == HELD) && ((bus.req & grant) == '0);
        timeout_hit = (state == HELD) && !release_hit && (cnt == CW'(MAXHOLD - 1));
        // The owner's one-hot grant rotated left is exactly "one past the last owner"
        base_ptr    = (release_hit || timeout_hit) ? {grant[N-2:0], grant[N-1]} : ptr;
    end

    // First requester at or after the pointer position, wrapping modulo N
    always_comb begin
        start_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (base_ptr[i]) start_idx = W'(i);
        end
        // Rotating req right by the pointer index turns the wrapped search into a plain LSB-first scan
        doubled = {bus.req, bus.req} >> start_idx;
        rot_req = doubled[N-1:0];
        found   = 1'b0;
        first   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!found && rot_req[j]) begin
                found = 1'b1;
                first = W'(j);
            end
        end
        sum = {1'b0, start_idx} + {1'b0, first};
        if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
        win_idx    = sum[W-1:0];
        win_onehot = found ? (N'(1) << win_idx) : '0;
    end

    // Next-state, grant and counter decisions
    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        cnt_next     = cnt;
        grant_next   = grant;
        owner_next   = owner;
        expired_next = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.en && found) begin
                    grant_next = win_onehot;
                    owner_next = win_idx;
                    cnt_next   = '0;
                    state_next = HELD;
                end else begin
                    grant_next = '0;
                    owner_next = '0;
                end
            end
            HELD: begin
                if (release_hit || timeout_hit) begin
                    ptr_next     = base_ptr;
                    expired_next = timeout_hit;
                    cnt_next     = '0;
                    if (bus.en && found) begin
                        grant_next = win_onehot;
                        owner_next = win_idx;
                    end else begin
                        grant_next = '0;
                        owner_next = '0;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= N'(1);
            cnt     <= '0;
            grant   <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            cnt     <= cnt_next;
            grant   <= grant_next;
            owner   <= owner_next;
            busy    <= |grant_next;
            expired <= expired_next;
        end
    end
endmodule

// File: tb/tb_ring_arbiter.sv
// Self-checking bench for ring_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural round-robin model.
module tb_ring_arbiter;
    localparam int NR = 4;
    localparam int WR = 2;
    localparam int MH = 8;

    logic clk;
    logic reset;

    ring_arbiter_if #(.N(NR), .W(WR)) bus ();

    ring_arbiter #(.N(NR), .W(WR), .MAXHOLD(MH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: whether a grant is held, who holds it, how many cycles
    // it has been visible, and which index currently has top priority.
    bit held;
    int m_owner;
    int m_age;
    int m_prio;
    bit m_expired;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int pick(input int prio, input logic [NR-1:0] q);
        for (int k = 0; k < NR; k++) begin
            if (q[(prio + k) % NR]) return (prio + k) % NR;
        end
        return -1;
    endfunction

    task automatic model_update(input logic r, input logic e, input logic [NR-1:0] q);
        int w;
        if (r) begin
            held = 0; m_owner = 0; m_age = 0; m_prio = 0; m_expired = 0;
            return;
        end
        m_expired = 0;
        w = -1;
        if (!held) begin
            if (e && q != 0) begin
                held = 1; m_owner = pick(m_prio, q); m_age = 1;
            end
        end else if (!q[m_owner] || m_age == MH) begin
            m_expired = q[m_owner];
            m_prio    = (m_owner + 1) % NR;
            if (e && q != 0) w = pick(m_prio, q);
            if (w >= 0) begin
                m_owner = w; m_age = 1;
            end else begin
                held = 0; m_owner = 0; m_age = 0;
            end
        end else begin
            m_age++;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [NR-1:0] q);
        int exp_grant;
        reset   = r;
        bus.en  = e;
        bus.req = q;
        @(posedge clk);
        model_update(r, e, q);
        #1;
        exp_grant = held ? (1 << m_owner) : 0;
        check("grant",   int'(bus.grant),   exp_grant);
        check("owner",   int'(bus.owner),   held ? m_owner : 0);
        check("busy",    int'(bus.busy),    int'(held));
        check("expired", int'(bus.expired), int'(m_expired));
        check("onehot",  int'($onehot0(bus.grant)), 1);
    endtask

    task automatic run(input logic e, input logic [NR-1:0] q, input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, e, q);
    endtask

    initial begin
        logic [NR-1:0] q;
        logic          e;
        logic          r;
        int            expired_seen;

        reset   = 1'b1;
        bus.en  = 1'b0;
        bus.req = '0;
        held = 0; m_owner = 0; m_age = 0; m_prio = 0; m_expired = 0;

        // Reset state
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b1111);

        // Single request, then a two-way contest shows priority moved to 1
        run(1'b1, 4'b0001, 3);
        check("single_grant_bits", int'(bus.grant), 1);
        run(1'b1, 4'b0000, 2);
        check("single_idle", int'(bus.busy), 0);
        step(1'b0, 1'b1, 4'b0011);
        check("ptr_after_single", int'(bus.grant), 2);
        run(1'b1, 4'b0000, 2);

        // Full-load rotation with expiry at every switch
        step(1'b1, 1'b0, 4'b0000);
        expired_seen = 0;
        for (int c = 0; c < 5 * MH; c++) begin
            step(1'b0, 1'b1, 4'b1111);
            if (bus.expired) expired_seen++;
        end
        check("rotation_expiries", expired_seen, 4);
        run(1'b1, 4'b0000, 2);

        // Early release handoff with no gap and no expiry
        step(1'b1, 1'b0, 4'b0000);
        run(1'b1, 4'b0101, 3);
        step(1'b0, 1'b1, 4'b0100);
        check("handoff_grant", int'(bus.grant), 4);
        check("handoff_noexp", int'(bus.expired), 0);
        run(1'b1, 4'b0000, 2);

        // Enable gating, then en dropped mid-grant
        run(1'b0, 4'b0010, 5);
        check("gated_idle", int'(bus.grant), 0);
        step(1'b0, 1'b1, 4'b0010);
        check("gated_grant", int'(bus.grant), 2);
        run(1'b0, 4'b0010, MH + 3);
        run(1'b0, 4'b0000, 2);

        // Sole requester held through two timeouts
        step(1'b1, 1'b0, 4'b0000);
        run(1'b1, 4'b1000, 20);
        check("sole_owner", int'(bus.owner), 3);
        run(1'b1, 4'b0000, 2);

        // Reset in the middle of a grant restores the pointer
        run(1'b1, 4'b0001, 1);
        run(1'b1, 4'b0100, 2);
        step(1'b1, 1'b1, 4'b0100);
        step(1'b0, 1'b1, 4'b1001);
        check("reset_ptr", int'(bus.grant), 1);

        // Random level-style traffic
        q = '0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) q = NR'($urandom);
            step(r, e, q);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
